// File: rtl/icache_tag_ways.sv
// Set-associative instruction-cache tag store with round-robin replacement.
// A self-clearing sweep wipes every set after reset or flush; lookups answer one cycle later.
module icache_tag_ways #(
    parameter int WAYS        = 2,
    parameter int SET_BITS    = 7,
    parameter int OFFSET_BITS = 5,
    parameter int ADDR_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lookup_en,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     hit,
    output logic [WAYS-1:0]          hit_way,
    output logic [$clog2(WAYS)-1:0]  victim_way,
    input  logic                     refill_en,
    input  logic [ADDR_W-1:0]        refill_addr,
    input  logic                     inv_en,
    input  logic [ADDR_W-1:0]        inv_addr,
    input  logic                     flush,
    output logic                     ready
);

    localparam int SETS     = 1 << SET_BITS;
    localparam int TAG_W    = ADDR_W - SET_BITS - OFFSET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int IDX_LO   = OFFSET_BITS;
    localparam int TAG_LO   = SET_BITS + OFFSET_BITS;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t                state_q, state_d;
    logic [SET_BITS-1:0]   count_q, count_d;
    logic                  hit_q, hit_d;
    logic [WAYS-1:0]       hitWay_q, hitWay_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;

    logic [WAYS-1:0]       validMem [SETS];
    logic [TAG_W-1:0]      tagMem   [SETS][WAYS];
    logic [WAY_BITS-1:0]   ptrMem   [SETS];

    logic [TAG_W-1:0]      lookupTag, refillTag;
    logic [SET_BITS-1:0]   lookupIdx, refillIdx, invIdx;
    logic [WAYS-1:0]       matchWay;
    logic                  lookupGo;
    logic                  refillDo;
    logic                  invDo;
    logic [WAY_BITS-1:0]   refillWay;
    logic [WAY_BITS-1:0]   refillWayNext;
    logic                  unusedAddrBits;

    assign lookupTag = lookup_addr[ADDR_W-1:TAG_LO];
    assign lookupIdx = lookup_addr[TAG_LO-1:IDX_LO];
    assign refillTag = refill_addr[ADDR_W-1:TAG_LO];
    assign refillIdx = refill_addr[TAG_LO-1:IDX_LO];
    assign invIdx    = inv_addr[TAG_LO-1:IDX_LO];

    assign unusedAddrBits = ^{lookup_addr[IDX_LO-1:0], refill_addr[IDX_LO-1:0],
                              inv_addr[IDX_LO-1:0], inv_addr[ADDR_W-1:TAG_LO]};

    // Maintenance writes only happen in IDLE without a flush; invalidate beats a refill of the same set.
    assign invDo    = (state_q == IDLE) && !flush && inv_en;
    assign refillDo = (state_q == IDLE) && !flush && refill_en &&
                      !(inv_en && (invIdx == refillIdx));

    assign refillWay     = ptrMem[refillIdx];
    assign refillWayNext = (refillWay == WAY_BITS'(WAYS - 1)) ? '0 : refillWay + WAY_BITS'(1);

    assign lookupGo = lookup_en && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = INIT;
            count_d = '0;
        end else if (state_q == INIT) begin
            count_d = count_q + SET_BITS'(1);
            if (count_q == SET_BITS'(SETS - 1)) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        matchWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            matchWay[w] = validMem[lookupIdx][w] && (tagMem[lookupIdx][w] == lookupTag);
        end
        hit_d    = lookupGo && (|matchWay);
        hitWay_d = lookupGo ? matchWay : '0;
        victim_d = lookupGo ? ptrMem[lookupIdx] : victim_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            count_q  <= '0;
            hit_q    <= 1'b0;
            hitWay_q <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hit_q    <= hit_d;
            hitWay_q <= hitWay_d;
            victim_q <= victim_d;
        end
    end

    // The array has no reset of its own; the INIT sweep clears one set per cycle.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            validMem[count_q] <= '0;
            ptrMem[count_q]   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                tagMem[count_q][w] <= '0;
            end
        end else begin
            if (refillDo) begin
                validMem[refillIdx][refillWay] <= 1'b1;
                tagMem[refillIdx][refillWay]   <= refillTag;
                ptrMem[refillIdx]              <= refillWayNext;
            end
            if (invDo) begin
                validMem[invIdx] <= '0;
            end
        end
    end

    assign hit        = hit_q;
    assign hit_way    = hitWay_q;
    assign victim_way = victim_q;
    assign ready      = (state_q == IDLE);

endmodule

// File: doc/icache_tag_ways.md
Name: icache_tag_ways

Overview:
- Set-associative tag store for the instruction cache; successor to the direct-mapped single-way tag array.
- Holds WAYS tags per set and runs a self-clearing init sweep after reset or flush.
- Returns registered hit, hit-way and victim-way one cycle after lookup. Supports refill with round-robin replacement, per-set invalidate and whole-cache flush.
- Sits between the fetch stage and the icache refill controller.

Parameters:
- WAYS, 2, associativity; legal values 2 or 4.
- SET_BITS, 7, index width; SETS = 2^SET_BITS.
- OFFSET_BITS, 5, line offset width (32-byte lines).
- ADDR_W, 32, address width. Localparams: TAG_W = ADDR_W-SET_BITS-OFFSET_BITS (20 by default); WAY_BITS = clog2(WAYS).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_en  in  1  lookup request this cycle.
- lookup_addr  in  ADDR_W  fetch address.
- hit  out  1  registered: last lookup matched a valid tag.
- hit_way  out  WAYS  registered one-hot matching way; all zero on miss.
- victim_way  out  WAY_BITS  registered replacement pointer of the looked-up set.
- refill_en  in  1  write tag of refill_addr into that set's victim way, set valid.
- refill_addr  in  ADDR_W  refill line address.
- inv_en  in  1  clear valid bits of all ways of set inv_addr[index].
- inv_addr  in  ADDR_W  invalidate address.
- flush  in  1  one-cycle pulse: restart init sweep, clearing the whole array.
- ready  out  1  high when not initialising.

Behaviour:
- Address split: tag = addr[ADDR_W-1 : SET_BITS+OFFSET_BITS]; index = addr[SET_BITS+OFFSET_BITS-1 : OFFSET_BITS]. Each entry holds a valid bit plus TAG_W tag bits. Each set has a WAY_BITS round-robin pointer.
- FSM states INIT and IDLE.
  - Reset enters INIT with clear counter 0.
  - INIT writes valid=0, tag=0 and pointer=0 to set[counter], all ways, then increments the counter.
  - Counter == SETS-1 moves to IDLE on the next edge.
  - flush in either state enters INIT with counter 0, restarting an in-progress sweep.
  - ready = (state==IDLE) and is registered. ready falls on the edge after flush.
- Reset (asynchronous, mid-operation included): state=INIT, counter=0, hit=0, hit_way=0, victim_way=0, ready=0. Array contents are not reset directly; the sweep clears them.
- Lookup has 1-cycle latency.
  - On the edge with lookup_en=1 and ready=1, register tag compare results for every way. hit = OR of (valid & tag match); victim_way = that set's pointer.
  - lookup_en=0 or ready=0: hit=0 and hit_way=0 next cycle; victim_way holds.
  - At most one way may match; a duplicate tag is a controller error and is not guarded.
- Array reads are read-before-write. A lookup in the same cycle as a refill or invalidate of the same set sees the old contents; the new contents are visible from the next cycle.
- Refill (IDLE only): way v = pointer[set] takes {1, tag}; pointer[set] becomes (v+1) mod WAYS. Hits do not move the pointer.
- Invalidate (IDLE only): valid=0 for all ways of the set; the pointer is unchanged.
- Simultaneous events and priority:
  - Refill and invalidate on the same set: invalidate wins, refill is dropped.
  - Refill and invalidate on different sets: both are performed.
  - refill_en or inv_en while in INIT, or in the same cycle as flush: ignored. The controller waits for ready.
- Pointer wrap: WAYS-1 wraps to 0.

Test Plan:
- Init sequence (defaults): deassert rst_n → ready=0 for exactly 128 cycles, then 1. Lookup 0x0000_0000 → hit=0, hit_way=00, victim_way=0.
- Refill then lookup:
  - Refill 0x1234_5040 (set 2, tag 0x12345) → next-cycle lookup 0x1234_505C gives hit=1, hit_way=01.
  - Lookup 0x5678_9040 → hit=0, victim_way=1.
- Replacement:
  - Refill 0x5678_9040, then refill 0xABCD_E040 → lookup 0x5678_9040 hits hit_way=10, and 0xABCD_E040 hits hit_way=01.
  - Lookup 0x1234_5040 → miss, victim_way=1.
- Invalidate and priority:
  - inv_en for set 2 → all set-2 lookups miss; lookup at set 3 keeps prior hits.
  - Same-cycle refill+inv on set 2 → miss afterwards.
  - Same-cycle lookup+refill of the same address → first lookup misses, next hits.
- Flush: flush pulse at cycle 50 of IDLE → ready low 128 cycles, refill_en during this window is ignored, all lookups then miss. A second flush mid-sweep restarts the count to a full 128.
- Asynchronous reset: assert rst_n low mid-refill and mid-sweep, between clock edges → hit, hit_way and ready go 0 immediately. After release, ready=0 for a full 128 cycles, then previously refilled addresses miss.
